bias_relu_bank: RTL

Layer-wide successor to the single-neuron bias stage. It holds one signed bias per neuron for a fully connected layer of `NUM_NEURONS` neurons. Weighted sums arrive one per neuron, in neuron order, over a valid/ready stream; the block adds the matching bias, saturates, optionally applies ReLU, and presents the result downstream. It also applies per-neuron bias updates (`bias -= delta`, saturating) from the training path and sits between the MAC accumulator and the activation/next-layer buffer.

---
 rtl/nn_pkg.sv | 40 ++++
 rtl/bias_regfile.sv | 51 +++++
 rtl/bias_relu_bank.sv | 121 ++++++++++++
 3 files changed

// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared width derivation and saturating arithmetic helpers
package nn_pkg;

    localparam int NWBITS_DEF     = 16;
    localparam int COUNT_BIT1_DEF = 10;
    localparam int MAXW           = 64;

    typedef logic signed [MAXW-1:0] wide_t;

    function automatic int sum_width(input int nwbits, input int count_bit1);
        return nwbits + count_bit1;
    endfunction

    // Operands are sign-extended to MAXW, so the raw sum/difference never wraps before the clamp.
    function automatic wide_t sat_clamp(input wide_t v, input int w);
        wide_t mx;
        wide_t mn;
        mx = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
        mn = -mx - wide_t'(1);
        if (v > mx)
            return mx;
        else if (v < mn)
            return mn;
        else
            return v;
    endfunction

    function automatic wide_t sat_add(input wide_t a, input wide_t b, input int w);
        return sat_clamp(a + b, w);
    endfunction

    function automatic wide_t sat_sub(input wide_t a, input wide_t b, input int w);
        return sat_clamp(a - b, w);
    endfunction

    function automatic wide_t relu(input wide_t v);
        return (v < 0) ? '0 : v;
    endfunction

endpackage

// File: rtl/bias_regfile.sv
// rtl/bias_regfile.sv - per-neuron bias registers, async read, saturating subtract write
module bias_regfile
    import nn_pkg::*;
#(
    parameter int NWBITS      = 16,
    parameter int NUM_NEURONS = 10,
    parameter int IDX_BITS    = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic [IDX_BITS-1:0]      rd_idx,
    output logic signed [NWBITS-1:0] rd_bias,
    input  logic                     wr_en,
    input  logic [IDX_BITS-1:0]      wr_idx,
    input  logic signed [NWBITS-1:0] wr_delta
);

    logic signed [NWBITS-1:0] bias_q [NUM_NEURONS];
    logic signed [NWBITS-1:0] bias_d [NUM_NEURONS];

    always_comb begin
        rd_bias = '0;
        for (int i = 0; i < NUM_NEURONS; i++) begin
            if (rd_idx == IDX_BITS'(i))
                rd_bias = bias_q[i];
        end
    end

    // Out-of-range write indices match no entry and fall through as a no-op.
    always_comb begin
        for (int i = 0; i < NUM_NEURONS; i++) begin
            bias_d[i] = bias_q[i];
            if (clear)
                bias_d[i] = '0;
            else if (wr_en && (wr_idx == IDX_BITS'(i)))
                bias_d[i] = NWBITS'(sat_sub(wide_t'(bias_q[i]), wide_t'(wr_delta), NWBITS));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_NEURONS; i++)
                bias_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_NEURONS; i++)
                bias_q[i] <= bias_d[i];
        end
    end

endmodule

// File: rtl/bias_relu_bank.sv
// rtl/bias_relu_bank.sv - layer-wide bias add, saturate and optional ReLU stage
module bias_relu_bank
    import nn_pkg::*;
#(
    parameter int  NWBITS      = NWBITS_DEF,
    parameter int  COUNT_BIT1  = COUNT_BIT1_DEF,
    parameter int  NUM_NEURONS = 10,
    parameter int  IDX_BITS    = 4,
    localparam int SW          = sum_width(NWBITS, COUNT_BIT1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     relu_en,
    input  logic                     sum_valid,
    output logic                     sum_ready,
    input  logic signed [SW-1:0]     weighted_sum,
    input  logic                     upd_valid,
    input  logic [IDX_BITS-1:0]      upd_idx,
    input  logic signed [NWBITS-1:0] upd_delta,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [SW-1:0]     out_data,
    output logic [IDX_BITS-1:0]      out_idx,
    output logic                     out_last,
    output logic                     end_layer,
    output logic                     busy
);

    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_NEURONS - 1);
    localparam logic [IDX_BITS:0]   NUM_EXT  = (IDX_BITS + 1)'(NUM_NEURONS);

    logic [IDX_BITS-1:0]  idx_q, idx_d;
    logic                 out_valid_q, out_valid_d;
    logic signed [SW-1:0] out_data_q, out_data_d;
    logic [IDX_BITS-1:0]  out_idx_q, out_idx_d;
    logic                 out_last_q, out_last_d;
    logic                 end_layer_q, end_layer_d;

    logic                     accept;
    logic                     out_hs;
    logic                     upd_we;
    logic signed [NWBITS-1:0] cur_bias;

    assign sum_ready = !out_valid_q || out_ready;
    assign accept    = sum_valid && sum_ready && !clear;
    assign out_hs    = out_valid_q && out_ready;
    assign upd_we    = upd_valid && !clear && ({1'b0, upd_idx} < NUM_EXT);

    // The add reads the bias combinationally, so a same-cycle update to this neuron lands after it.
    bias_regfile #(
        .NWBITS      (NWBITS),
        .NUM_NEURONS (NUM_NEURONS),
        .IDX_BITS    (IDX_BITS)
    ) u_bias_regfile (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .rd_idx   (idx_q),
        .rd_bias  (cur_bias),
        .wr_en    (upd_we),
        .wr_idx   (upd_idx),
        .wr_delta (upd_delta)
    );

    always_comb begin
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
        end_layer_d = out_hs && out_last_q;

        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = relu_en
                        ? SW'(relu(sat_add(wide_t'(weighted_sum), wide_t'(cur_bias), SW)))
                        : SW'(sat_add(wide_t'(weighted_sum), wide_t'(cur_bias), SW));
            out_idx_d   = idx_q;
            out_last_d  = (idx_q == LAST_IDX);
            idx_d       = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        end else if (out_hs) begin
            out_valid_d = 1'b0;
        end

        if (clear) begin
            idx_d       = '0;
            out_valid_d = 1'b0;
            out_data_d  = '0;
            out_idx_d   = '0;
            out_last_d  = 1'b0;
            end_layer_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            end_layer_q <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
            end_layer_q <= end_layer_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;
    assign end_layer = end_layer_q;
    assign busy      = (idx_q != '0) || out_valid_q;

endmodule
